current_switch_bank: RTL and testbench

CURRENT_SWITCH_BANK -- requirements
Module: current_switch_bank

---
 rtl/current_switch_bank.sv | 149 ++++++++++++++
 tb/tb_current_switch_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/current_switch_bank.sv
// current_switch_bank
//   Bank of N_CH independent make/break switches steering a signed level.
//   Each channel has a three-state FSM (OFF -> DEAD -> ON). The switch
//   conducts only once the make delay has elapsed. Breaking is immediate.
//   The output is v_in scaled by the summed weight of the conducting
//   channels. It is registered and saturated to the WIDTH-bit signed range.
//
// Parameters
//   N_CH     number of channels (1..16)
//   WIDTH    signed width of v_in / v_out
//   DEAD_CYC make delay in clk edges for OFF->ON (0..255)
//   MODE     0: channel i weighs 2^i, 1: every channel weighs 1
//
// Ports
//   clk       emulation clock, rising edge
//   rst       asynchronous active-high reset
//   v_in      signed source level
//   ctrl      per-channel requested switch state (1 = on)
//   v_out     signed, registered, saturated output level
//   sw_state  per-channel conducting state (1 = ON)
//   busy      high while any channel is in DEAD
//   dbg_state packed per-channel FSM state, channel i at [2*i+1:2*i]
//             (00 OFF, 01 DEAD, 10 ON)
//
// Handshake: none. ctrl is a level request sampled on every rising clk
// edge. There is no valid/ready pairing on this block.
module current_switch_bank #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 16,
  parameter int DEAD_CYC = 2,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    v_in,
  input  logic [N_CH-1:0]     ctrl,
  output logic [WIDTH-1:0]    v_out,
  output logic [N_CH-1:0]     sw_state,
  output logic                busy,
  output logic [2*N_CH-1:0]   dbg_state
);

  // Weight-sum width: binary needs N_CH+1 bits, unary needs enough bits to
  // count up to N_CH.
  localparam int WW = (MODE == 0) ? (N_CH + 1) : $clog2(N_CH + 1);
  // Signed product width. The weight gets a zero sign bit, so the product
  // always fits without overflow.
  localparam int PW = WIDTH + WW + 1;

  localparam logic signed [PW-1:0] SAT_HI = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_DEAD = 2'b01,
    ST_ON   = 2'b10
  } st_t;

  logic [N_CH-1:0] dead_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    st_t        state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_OFF;
        cnt_q   <= 8'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_OFF: begin
          if (ctrl[i]) begin
            if (DEAD_CYC == 0) begin
              state_d = ST_ON;
            end else begin
              state_d = ST_DEAD;
              cnt_d   = 8'(DEAD_CYC);
            end
          end
        end
        ST_DEAD: begin
          if (!ctrl[i]) begin
            state_d = ST_OFF;
            cnt_d   = 8'd0;
          end else if (cnt_q <= 8'd1) begin
            // The edge that sees cnt==1 is the last DEAD edge. That puts ON
            // exactly DEAD_CYC edges after the OFF->DEAD edge.
            state_d = ST_ON;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_ON: begin
          if (!ctrl[i]) state_d = ST_OFF;
        end
        default: begin
          // Unused encoding 2'b11 falls back to a safe, non-conducting state.
          state_d = ST_OFF;
          cnt_d   = 8'd0;
        end
      endcase
    end

    assign sw_state[i]          = (state_q == ST_ON);
    assign dead_vec[i]          = (state_q == ST_DEAD);
    assign dbg_state[2*i +: 2]  = state_q;
  end

  assign busy = |dead_vec;

  // Summed weight of the conducting channels.
  logic [WW-1:0] w_sum;
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sw_state[i]) begin
        if (MODE == 0) w_sum = w_sum + (WW'(1) << i);
        else           w_sum = w_sum + WW'(1);
      end
    end
  end

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic        [WIDTH-1:0] v_sat;

  always_comb begin
    a_ext = PW'($signed(v_in));
    b_ext = $signed(PW'({1'b0, w_sum}));
    prod  = a_ext * b_ext;
    if (prod > SAT_HI)      v_sat = SAT_HI[WIDTH-1:0];
    else if (prod < SAT_LO) v_sat = SAT_LO[WIDTH-1:0];
    else                    v_sat = prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_out <= '0;
    else     v_out <= v_sat;
  end

endmodule

// File: tb/tb_current_switch_bank.sv
// tb_current_switch_bank
//   Directed bench for current_switch_bank. Four instances share clk/rst:
//     u_a: defaults (binary, DEAD_CYC=2)
//     u_u: unary weighting
//     u_c: DEAD_CYC=4
//     u_z: DEAD_CYC=0
//   Inputs change 1 time unit after a rising edge. Outputs are checked at
//   that same point.
module tb_current_switch_bank;

  logic clk;
  logic rst;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        [15:0] va_in, vu_in, vc_in, vz_in;
  logic signed [15:0] va_out, vu_out, vc_out, vz_out;
  logic        [3:0]  ca, cu, cc, cz;
  logic        [3:0]  swa, swu, swc, swz;
  logic               busya, busyu, busyc, busyz;
  logic        [7:0]  dbga, dbgu, dbgc, dbgz;

  current_switch_bank u_a (
    .clk(clk), .rst(rst), .v_in(va_in), .ctrl(ca), .v_out(va_out),
    .sw_state(swa), .busy(busya), .dbg_state(dbga)
  );

  current_switch_bank #(.MODE(1)) u_u (
    .clk(clk), .rst(rst), .v_in(vu_in), .ctrl(cu), .v_out(vu_out),
    .sw_state(swu), .busy(busyu), .dbg_state(dbgu)
  );

  current_switch_bank #(.DEAD_CYC(4)) u_c (
    .clk(clk), .rst(rst), .v_in(vc_in), .ctrl(cc), .v_out(vc_out),
    .sw_state(swc), .busy(busyc), .dbg_state(dbgc)
  );

  current_switch_bank #(.DEAD_CYC(0)) u_z (
    .clk(clk), .rst(rst), .v_in(vz_in), .ctrl(cz), .v_out(vz_out),
    .sw_state(swz), .busy(busyz), .dbg_state(dbgz)
  );

  // ---------------- checking ----------------
  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    va_in = '0; vu_in = '0; vc_in = '0; vz_in = '0;
    ca    = '0; cu    = '0; cc    = '0; cz    = '0;

    // Reset state
    tick(); tick();
    chk("rst_vout", va_out, 0);
    chk("rst_sw",   swa,    0);
    chk("rst_busy", busya,  0);
    rst = 1'b0;

    // Make delay, defaults: DEAD after E0 and E1, ON after E2, v_out after E3
    va_in = 16'd100;
    ca    = 4'b0001;
    tick();
    chk("make_e0_busy", busya, 1);
    chk("make_e0_sw",   swa,   0);
    chk("make_e0_dbg",  dbga,  8'b0000_0001);
    tick();
    chk("make_e1_busy", busya, 1);
    chk("make_e1_sw",   swa,   0);
    tick();
    chk("make_e2_sw",   swa,   4'b0001);
    chk("make_e2_busy", busya, 0);
    chk("make_e2_vout", va_out, 0);
    tick();
    chk("make_e3_vout", va_out, 100);

    // Binary weighting and saturation
    ca    = 4'b1111;
    va_in = 16'd3000;
    tick(); tick(); tick();
    chk("bin_sw",      swa,    4'b1111);
    chk("bin_vout_w1", va_out, 3000);
    tick();
    chk("bin_sat_hi",  va_out, 32767);
    va_in = 16'd2184;
    tick();
    chk("bin_nosat_hi", va_out, 32760);
    va_in = 16'(-3000);
    tick();
    chk("bin_sat_lo",  va_out, -32768);
    va_in = 16'(-2184);
    tick();
    chk("bin_nosat_lo", va_out, -32760);

    // Immediate break with DEAD_CYC=2
    ca = 4'b1110;
    tick();
    chk("brk_sw",   swa,    4'b1110);
    chk("brk_vout", va_out, -32760);
    tick();
    chk("brk_vout_w14", va_out, -30576);

    // Unary weighting
    vu_in = 16'(-1000);
    cu    = 4'b0111;
    tick(); tick(); tick(); tick();
    chk("una_sw",   swu,    4'b0111);
    chk("una_vout", vu_out, -3000);
    cu = 4'b0101;
    tick();
    chk("una_sw2",        swu,    4'b0101);
    chk("una_vout_hold",  vu_out, -3000);
    tick();
    chk("una_vout2",      vu_out, -2000);

    // Cancelled make, DEAD_CYC=4
    vc_in = 16'd500;
    cc    = 4'b0010;
    tick();
    chk("cxl_e0_busy", busyc, 1);
    chk("cxl_e0_sw",   swc,   0);
    tick();
    chk("cxl_e1_busy", busyc, 1);
    chk("cxl_e1_sw",   swc,   0);
    cc = 4'b0000;
    tick();
    chk("cxl_e2_busy", busyc, 0);
    chk("cxl_e2_sw",   swc,   0);
    chk("cxl_e2_vout", vc_out, 0);
    tick();
    chk("cxl_e3_sw",   swc,   0);
    chk("cxl_e3_vout", vc_out, 0);

    // Full make with DEAD_CYC=4: ON exactly 4 edges after leaving OFF
    cc = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("mk4_e3_busy", busyc, 1);
    chk("mk4_e3_sw",   swc,   0);
    tick();
    chk("mk4_e4_sw",   swc,   4'b0010);
    chk("mk4_e4_busy", busyc, 0);
    tick();
    chk("mk4_vout",    vc_out, 1000);

    // Zero delay: ON next edge, never busy; immediate break
    vz_in = 16'd7;
    cz    = 4'b0001;
    tick();
    chk("z_sw",   swz,   4'b0001);
    chk("z_busy", busyz, 0);
    tick();
    chk("z_vout", vz_out, 7);
    cz = 4'b0000;
    tick();
    chk("z_brk_sw", swz, 0);

    // Reset mid-operation: ch2 ON, ch0 entering DEAD
    ca = 4'b0101;
    tick();
    chk("pre_rst_sw",   swa,   4'b0100);
    chk("pre_rst_busy", busya, 1);
    rst = 1'b1;
    #2;
    chk("async_rst_sw",   swa,    0);
    chk("async_rst_busy", busya,  0);
    chk("async_rst_vout", va_out, 0);
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_e0_busy", busya, 1);
    chk("post_rst_e0_sw",   swa,   0);
    tick();
    chk("post_rst_e1_busy", busya, 1);
    tick();
    chk("post_rst_e2_sw",   swa,   4'b0101);
    tick();
    chk("post_rst_vout",    va_out, -10920);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
